// File: rtl/wb_addr_router.sv
// wb_addr_router: Wishbone classic base/mask address router with error response and sticky IRQ; `define WB_ROUTER_TIMEOUT_EN adds a REQ timeout
module wb_addr_router #(
  parameter int N_SLV = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [N_SLV*AW-1:0] SLV_BASE = {32'h3800_0000, 32'h3002_0000, 32'h3001_0000, 32'h3000_0000},
  parameter logic [N_SLV*AW-1:0] SLV_MASK = {4{32'hFFFF_0000}},
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                wbs_clk_i,
  input  logic                wbs_rst_n_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [DW/8-1:0]     wbs_sel_i,
  input  logic [AW-1:0]       wbs_adr_i,
  input  logic [DW-1:0]       wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [DW-1:0]       wbs_dat_o,
  output logic [N_SLV-1:0]    m_cyc_o,
  output logic [N_SLV-1:0]    m_stb_o,
  output logic                m_we_o,
  output logic [DW/8-1:0]     m_sel_o,
  output logic [AW-1:0]       m_adr_o,
  output logic [DW-1:0]       m_dat_o,
  input  logic [N_SLV*DW-1:0] m_dat_i,
  input  logic [N_SLV-1:0]    m_ack_i,
  input  logic                err_clr_i,
  output logic                err_irq_o
);
  localparam int IW = N_SLV > 1 ? $clog2(N_SLV) : 1;
  typedef enum logic [1:0] {IDLE, REQ, ERR, RESP} state_t;
  state_t state;
  logic [N_SLV-1:0] m_req;
  logic [IW-1:0] sel_idx, hit_idx;
  logic hit;
`ifdef WB_ROUTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
`endif
  assign m_cyc_o = m_req;
  assign m_stb_o = m_req;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--)
      if ((wbs_adr_i & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end
  always_ff @(posedge wbs_clk_i) begin
    if (!wbs_rst_n_i) begin
      state <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      m_req <= '0;
      m_we_o <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      sel_idx <= '0;
      err_irq_o <= 1'b0;
`ifdef WB_ROUTER_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      err_irq_o <= state == ERR || (err_irq_o && !err_clr_i);
`ifdef WB_ROUTER_TIMEOUT_EN
      tmo_cnt <= state == REQ ? tmo_cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE: if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o) begin
          m_we_o <= wbs_we_i;
          m_sel_o <= wbs_sel_i;
          m_adr_o <= wbs_adr_i;
          m_dat_o <= wbs_dat_i;
          sel_idx <= hit_idx;
          m_req <= hit ? N_SLV'(1) << hit_idx : '0;
          state <= hit ? REQ : ERR;
        end
        REQ: begin
          if (!wbs_cyc_i) begin
            m_req <= '0;
            state <= IDLE;
          end else if (m_ack_i[sel_idx]) begin
            m_req <= '0;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= m_we_o ? '0 : m_dat_i[sel_idx*DW +: DW];
            state <= RESP;
          end
`ifdef WB_ROUTER_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            m_req <= '0;
            state <= ERR;
          end
`else
          else state <= REQ;
`endif
        end
        ERR: begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= ERR_DATA;
          state <= RESP;
        end
        RESP: begin
          wbs_ack_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_addr_router.sv
// tb_wb_addr_router: randomized scoreboard bench for wb_addr_router against an address-map reference model
module tb_wb_addr_router;
  localparam int N = 4, AW = 32, DW = 32, TMO = 8;
  localparam logic [N*AW-1:0] BASE = {32'h3000_0000, 32'h3002_0000, 32'h3001_0000, 32'h3000_0000};
  localparam logic [N*AW-1:0] MASK = {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
  typedef struct {
    logic we;
    logic [31:0] adr, wd, exp;
    logic [3:0] sel;
    int port, fixed, issue;
    bit clr, err;
  } item_t;
  logic clk = 0, rst_n = 0, cyc = 0, stb = 0, we = 0, err_clr = 0;
  logic [3:0] sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic ack, m_we, irq;
  logic [31:0] rdat, m_adr, m_dat;
  logic [3:0] m_sel;
  logic [N-1:0] m_cyc, m_stb;
  logic [N-1:0] m_ack = '0;
  logic [N*DW-1:0] m_dat_i = '0;
  int cyc_n = 0, n_chk = 0, n_pass = 0, slv_ack_cyc = 0, force_dly = -1;
  bit hold_ack = 0, model_irq = 0;
  item_t sb[$];
  logic [31:0] ref_base[N] = '{32'h3000_0000, 32'h3001_0000, 32'h3002_0000, 32'h3000_0000};
  logic [31:0] ref_mask[N] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000};
  logic [31:0] pick_base[5] = '{32'h3000_0000, 32'h3001_0000, 32'h3002_0000, 32'h30F0_0000, 32'h4000_0000};
  wb_addr_router #(.N_SLV(N), .AW(AW), .DW(DW), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TMO)) dut (
    .wbs_clk_i(clk), .wbs_rst_n_i(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel), .m_adr_o(m_adr), .m_dat_o(m_dat),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack), .err_clr_i(err_clr), .err_irq_o(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
  endtask
  function automatic int ref_port(input logic [31:0] a);
    for (int i = 0; i < N; i++) if ((a & ref_mask[i]) == (ref_base[i] & ref_mask[i])) return i;
    return -1;
  endfunction
  function automatic logic [31:0] rdata(input int i, input logic [31:0] a);
    return a ^ (32'h9E37_79B9 * 32'(i + 1));
  endfunction
  function automatic item_t make_item(input logic w, input logic [31:0] a, d, input logic [3:0] s, input bit clr);
    item_t it;
    it.we = w;
    it.adr = a;
    it.wd = d;
    it.sel = s;
    it.clr = clr;
    it.port = ref_port(a);
    it.issue = cyc_n;
    it.err = it.port < 0 || hold_ack;
    it.exp = it.err ? 32'hDEAD_BEEF : w ? 32'h0 : rdata(it.port, a);
    it.fixed = it.port < 0 ? 2 : hold_ack ? TMO + 2 : 0;
    return it;
  endfunction
  task automatic xfer(input logic w, input logic [31:0] a, d, input logic [3:0] s, input bit clr);
    int n = 0;
    sb.push_back(make_item(w, a, d, s, clr));
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s; err_clr = clr;
    do begin @(negedge clk); n++; end while (!ack && n < 60);
    if (!ack) begin
      chk("ack_wait", ack, 1);
      sb.delete();
    end
    cyc = 0; stb = 0; we = 0; err_clr = 0;
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask
  task automatic clr_pulse();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    model_irq = 0;
    chk("irq_clr", irq, 0);
  endtask
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (rst_n && ack) begin
        if (sb.size() == 0) chk("unexpected_ack", ack, 0);
        else begin
          it = sb.pop_front();
          chk("wbs_dat", rdat, it.exp);
          chk("latency", cyc_n, it.fixed != 0 ? it.issue + it.fixed : slv_ack_cyc + 1);
          model_irq = it.err ? 1'b1 : it.clr ? 1'b0 : model_irq;
          chk("irq", irq, model_irq);
        end
      end
    end
  end
  initial begin
    int dly[N];
    bit busy[N];
    forever begin
      @(negedge clk);
      m_ack = '0;
      for (int i = 0; i < N; i++) begin
        if (m_stb[i]) begin
          if (!busy[i]) begin
            busy[i] = 1;
            dly[i] = force_dly >= 0 ? force_dly : $urandom_range(0, 4);
            chk("target", i, sb.size() ? sb[0].port : -1);
          end
          if (!hold_ack) begin
            if (dly[i] == 0) begin
              m_ack[i] = 1;
              m_dat_i[i*DW +: DW] = rdata(i, m_adr);
              slv_ack_cyc = cyc_n;
              busy[i] = 0;
              if (sb.size()) begin
                chk("m_adr", m_adr, sb[0].adr);
                chk("m_we", m_we, sb[0].we);
                chk("m_sel", m_sel, sb[0].sel);
                if (sb[0].we) chk("m_dat", m_dat, sb[0].wd);
              end
            end else dly[i]--;
          end
        end else begin
          busy[i] = 0;
          if (m_stb != 0 && $urandom_range(0, 2) == 0) begin
            m_ack[i] = 1;
            m_dat_i[i*DW +: DW] = $urandom;
          end
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_cyc", m_cyc, 0);
    chk("rst_stb", m_stb, 0);
    chk("rst_we", m_we, 0);
    chk("rst_sel", m_sel, 0);
    chk("rst_adr", m_adr, 0);
    chk("rst_mdat", m_dat, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1;
    @(negedge clk);
    force_dly = 2;
    xfer(1, 32'h3001_0000, 32'h1234_5678, 4'hF, 0);
    force_dly = 0;
    xfer(0, 32'h3000_0004, 32'h0, 4'hF, 0);
    force_dly = -1;
    xfer(0, 32'h1000_0000, 32'h0, 4'hF, 0);
    clr_pulse();
    xfer(0, 32'h3000_0100, 32'h0, 4'h3, 0);
    xfer(1, 32'h30F0_0200, 32'hA5A5_0F0F, 4'hC, 0);
    xfer(0, 32'h4000_0000, 32'h0, 4'hF, 1);
    xfer(1, 32'h5000_0008, 32'h1111_2222, 4'hF, 0);
    clr_pulse();
    for (int k = 0; k < 200; k++) begin
      a = pick_base[$urandom_range(0, 4)] | ($urandom & 32'h0000_FFFC);
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) clr_pulse();
    end
    xfer(0, 32'h7000_0000, 32'h0, 4'hF, 0);
    hold_ack = 1;
    sb.push_back(make_item(0, 32'h3002_0010, 32'h0, 4'hF, 0));
    cyc = 1; stb = 1; we = 0; adr = 32'h3002_0010; sel = 4'hF;
    repeat (2) @(negedge clk);
    cyc = 0; stb = 0;
    sb.delete();
    @(negedge clk);
    chk("abort_stb", m_stb, 0);
    repeat (3) @(negedge clk);
    sb.push_back(make_item(0, 32'h3000_0010, 32'h0, 4'hF, 0));
    cyc = 1; stb = 1; adr = 32'h3000_0010;
    repeat (3) @(negedge clk);
    chk("req_stb", m_stb, 4'b0001);
    rst_n = 0;
    @(negedge clk);
    chk("rstreq_stb", m_stb, 0);
    chk("rstreq_ack", ack, 0);
    chk("rstreq_irq", irq, 0);
    cyc = 0; stb = 0; rst_n = 1; hold_ack = 0; model_irq = 0;
    sb.delete();
    @(negedge clk);
    xfer(0, 32'h3001_0020, 32'h0, 4'hF, 0);
`ifdef WB_ROUTER_TIMEOUT_EN
    hold_ack = 1;
    xfer(0, 32'h3002_0040, 32'h0, 4'hF, 0);
    hold_ack = 0;
    xfer(1, 32'h3002_0044, 32'hFEED_F00D, 4'hF, 0);
`endif
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
